// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS main control FSM with memory stall and retire counter
// Optional feature macro: MULTICYCLE_JUMP_EN (adds the J instruction via the JUMP state).
module multicycle_control #(
   parameter int CNT_W   = 32,
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [5:0]         opcode,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               pc_write_cond,
   output logic               i_or_d,
   output logic               mem_read,
   output logic               mem_write,
   output logic               ir_write,
   output logic               mem_to_reg,
   output logic               reg_dst,
   output logic               reg_write,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         alu_op,
   output logic [1:0]         pc_source,
   output logic [STATE_W-1:0] state_out,
   output logic               illegal_op,
   output logic [CNT_W-1:0]   instr_count
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEM_ADDR = 4'd2,
      MEM_RD   = 4'd3,
      MEM_WB   = 4'd4,
      MEM_WR   = 4'd5,
      EXEC     = 4'd6,
      R_WB     = 4'd7,
      BRANCH   = 4'd8,
      JUMP     = 4'd9
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef MULTICYCLE_JUMP_EN
   localparam logic [5:0] OP_J     = 6'b000010;
`endif

   state_t           state_q, state_d;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             retire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= FETCH;
         illegal_q <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
         count_q   <= count_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      retire    = 1'b0;
      case (state_q)
         FETCH:    if (mem_ready) state_d = DECODE;
         DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = MEM_ADDR;
               OP_RTYPE:     state_d = EXEC;
               OP_BEQ:       state_d = BRANCH;
`ifdef MULTICYCLE_JUMP_EN
               OP_J:         state_d = JUMP;
`endif
               default: begin
                  state_d   = FETCH;
                  illegal_d = 1'b1;
               end
            endcase
         end
         MEM_ADDR: state_d = (opcode == OP_LW) ? MEM_RD : MEM_WR;
         MEM_RD:   if (mem_ready) state_d = MEM_WB;
         MEM_WB: begin
            retire  = 1'b1;
            state_d = FETCH;
         end
         MEM_WR: begin
            if (mem_ready) begin
               retire  = 1'b1;
               state_d = FETCH;
            end
         end
         EXEC:     state_d = R_WB;
         R_WB: begin
            retire  = 1'b1;
            state_d = FETCH;
         end
         BRANCH: begin
            retire  = 1'b1;
            state_d = FETCH;
         end
         JUMP: begin
`ifdef MULTICYCLE_JUMP_EN
            retire  = 1'b1;
`endif
            state_d = FETCH;
         end
         default:  state_d = FETCH;
      endcase
      count_d = retire ? count_q + CNT_W'(1) : count_q;
   end

   // Outputs are gated by rst_n so no strobe survives the falling reset edge.
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      if (rst_n) begin
         case (state_q)
            FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = 2'b01;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            DECODE:   alu_src_b = 2'b11;
            MEM_ADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
            end
            MEM_RD: begin
               mem_read = 1'b1;
               i_or_d   = 1'b1;
            end
            MEM_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
            end
            MEM_WR: begin
               mem_write = 1'b1;
               i_or_d    = 1'b1;
            end
            EXEC: begin
               alu_src_a = 1'b1;
               alu_op    = 2'b10;
            end
            R_WB: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
            end
            BRANCH: begin
               alu_src_a     = 1'b1;
               alu_op        = 2'b01;
               pc_write_cond = 1'b1;
               pc_source     = 2'b01;
            end
`ifdef MULTICYCLE_JUMP_EN
            JUMP: begin
               pc_write  = 1'b1;
               pc_source = 2'b10;
            end
`endif
            default: ;
         endcase
      end
   end

   assign state_out   = STATE_W'(state_q);
   assign illegal_op  = illegal_q;
   assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;
   localparam int CNT_W   = 32;
   localparam int STATE_W = 4;

   localparam logic [3:0] S_F = 4'd0, S_D = 4'd1, S_MA = 4'd2, S_MR = 4'd3, S_MWB = 4'd4,
                          S_MW = 4'd5, S_EX = 4'd6, S_RWB = 4'd7, S_BR = 4'd8, S_J = 4'd9;
   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                          OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_BAD = 6'b111111;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic mem_ready = 1'b0;
   logic [5:0] opcode = 6'd0;
   logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic mem_to_reg, reg_dst, reg_write, alu_src_a;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic [STATE_W-1:0] state_out;
   logic illegal_op;
   logic [CNT_W-1:0] instr_count;
   logic [15:0] ctl;

   multicycle_control #(.CNT_W(CNT_W), .STATE_W(STATE_W)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .state_out(state_out), .illegal_op(illegal_op),
      .instr_count(instr_count)
   );

   assign ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                 mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   logic [CNT_W-1:0] exp_count = '0;
   logic exp_illegal = 1'b0;

   typedef struct packed {
      logic [3:0] st;
      logic       mr;
      logic [5:0] op;
   } exp_t;
   exp_t sb[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] exp_ctl(input logic [3:0] st, input logic mr);
      logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
      logic [1:0] asb, aop, psrc;
      {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa} = '0;
      asb = 2'b00; aop = 2'b00; psrc = 2'b00;
      case (st)
         S_F:   begin mrd = 1'b1; asb = 2'b01; irw = mr; pcw = mr; end
         S_D:   asb = 2'b11;
         S_MA:  begin asa = 1'b1; asb = 2'b10; end
         S_MR:  begin mrd = 1'b1; iord = 1'b1; end
         S_MWB: begin rw = 1'b1; m2r = 1'b1; end
         S_MW:  begin mwr = 1'b1; iord = 1'b1; end
         S_EX:  begin asa = 1'b1; aop = 2'b10; end
         S_RWB: begin rw = 1'b1; rdst = 1'b1; end
         S_BR:  begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; psrc = 2'b01; end
         S_J:   begin pcw = 1'b1; psrc = 2'b10; end
         default: ;
      endcase
      return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc};
   endfunction

   function automatic logic op_legal(input logic [5:0] op);
`ifdef MULTICYCLE_JUMP_EN
      return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_J);
`else
      return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ);
`endif
   endfunction

   // Called just after a rising edge: drive the cycle, expect the given state.
   task automatic step(input logic [3:0] st, input logic mr, input logic [5:0] op);
      exp_t e;
      mem_ready = mr;
      opcode    = op;
      e.st = st; e.mr = mr; e.op = op;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("state@%0t", $time), 64'(state_out), 64'(e.st));
      check($sformatf("ctl_s%0d", e.st), 64'(ctl), 64'(exp_ctl(e.st, e.mr)));
      check("count", 64'(instr_count), 64'(exp_count));
      check("illegal", 64'(illegal_op), 64'(exp_illegal));
      if (e.st == S_MWB || e.st == S_RWB || e.st == S_BR || e.st == S_J || (e.st == S_MW && e.mr))
         exp_count = exp_count + 1'b1;
      if (e.st == S_D && !op_legal(e.op))
         exp_illegal = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #8;
      check("rst_state", 64'(state_out), 64'd0);
      check("rst_ctl", 64'(ctl), 64'd0);
      check("rst_count", 64'(instr_count), 64'd0);
      check("rst_illegal", 64'(illegal_op), 64'd0);
      #4 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // R-type; opcode glitch during EXEC must be ignored
      step(S_F, 1, OP_R); step(S_D, 1, OP_R); step(S_EX, 1, OP_BAD); step(S_RWB, 1, OP_R);
      // LW with two memory wait cycles
      step(S_F, 1, OP_LW); step(S_D, 1, OP_LW); step(S_MA, 1, OP_LW);
      step(S_MR, 0, OP_LW); step(S_MR, 0, OP_LW); step(S_MR, 1, OP_LW); step(S_MWB, 1, OP_LW);
      // FETCH stall then R-type
      for (int i = 0; i < 3; i++) step(S_F, 0, OP_R);
      step(S_F, 1, OP_R); step(S_D, 1, OP_R); step(S_EX, 1, OP_R); step(S_RWB, 1, OP_R);
      // BEQ then SW (one write wait)
      step(S_F, 1, OP_BEQ); step(S_D, 1, OP_BEQ); step(S_BR, 1, OP_BEQ);
      step(S_F, 1, OP_SW); step(S_D, 1, OP_SW); step(S_MA, 1, OP_SW);
      step(S_MW, 0, OP_SW); step(S_MW, 1, OP_SW);
      // Jump opcode
      step(S_F, 1, OP_J); step(S_D, 1, OP_J);
`ifdef MULTICYCLE_JUMP_EN
      step(S_J, 1, OP_J);
`endif
      // Unsupported opcode
      step(S_F, 1, OP_BAD); step(S_D, 1, OP_BAD);
      // Asynchronous reset in the middle of MEM_RD
      step(S_F, 1, OP_LW); step(S_D, 1, OP_LW); step(S_MA, 1, OP_LW); step(S_MR, 0, OP_LW);
      #2 rst_n = 1'b0;
      #1;
      check("arst_state", 64'(state_out), 64'd0);
      check("arst_ctl", 64'(ctl), 64'd0);
      check("arst_count", 64'(instr_count), 64'd0);
      check("arst_illegal", 64'(illegal_op), 64'd0);
      exp_count   = '0;
      exp_illegal = 1'b0;
      @(negedge clk);
      #1 rst_n = 1'b1;
      #1;
      check("rel_state", 64'(state_out), 64'd0);
      check("rel_ctl", 64'(ctl), 64'(exp_ctl(S_F, 1'b0)));
      @(posedge clk);
      #1;
      step(S_F, 1, OP_R); step(S_D, 1, OP_R); step(S_EX, 1, OP_R); step(S_RWB, 1, OP_R);
      step(S_F, 0, OP_R);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
